uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver shifter. It watches the receiver's busy output, captures each completed word when busy falls, and stores it in a small circular FIFO. The FIFO is first-word-fall-through with a pop strobe. The block also drives the receiver's read-enable and holds a sticky overflow flag for the host/register side.

Parameters:
BIT_WIDTH, 8, word width; must match the receiver's BIT_WIDTH
DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8)

Ports:
clk  input  1  system clock; all state on posedge
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  host enable for reception
rx_busy  input  1  busy from the receiver
rx_data  input  BIT_WIDTH  dataOut from the receiver; valid in the cycle busy falls
rx_en  output  1  read-enable to the receiver; combinational, en & ~full
rd_en  input  1  pop strobe; ignored when empty
rd_data  output  BIT_WIDTH  head word; all zeros when empty
empty  output  1  count == 0
full  output  1  count == 2**DEPTH_LOG2
count  output  DEPTH_LOG2+1  number of stored words
overflow  output  1  sticky; a word was dropped
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, asynchronous): state=s_WAIT_IDLE, wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Resulting outputs: empty=1, full=0, rd_data=0, rx_en=en.
  - Memory contents are not reset.
- Capture FSM (2-bit state):
  - s_WAIT_IDLE: waits for rx_busy=0, then goes to s_IDLE. No capture is possible in this state, so a word in flight at reset release is discarded.
  - s_IDLE: rx_busy=1 -> s_BUSY; otherwise stay.
  - s_BUSY: rx_busy=0 -> s_IDLE and assert push for that cycle (combinational), capturing rx_data in the same cycle. rx_busy=1 -> stay.
  - Unused encoding -> s_WAIT_IDLE.
- Push (write side):
  - When push=1 and not full: mem[wr_ptr] <= rx_data; wr_ptr increments and wraps modulo depth.
- Pop (read side):
  - When rd_en=1 and not empty: rd_ptr increments and wraps.
  - rd_data = mem[rd_ptr] combinationally, so the new head is visible in the cycle after the pop.
- count update:
  - +1 on an accepted push only; -1 on an accepted pop only.
  - Unchanged when both or neither are accepted.
- Simultaneous events:
  - Push and pop while full: both are accepted, count stays at depth, no overflow.
  - Push and pop while empty: push accepted, pop ignored, count becomes 1.
  - Push while full without pop: word dropped, pointers and count unchanged, overflow <= 1.
  - ovf_clr and an overflow event in the same cycle: set wins, overflow=1.
- Pointer width is DEPTH_LOG2; wrap is natural overflow. count width is DEPTH_LOG2+1 so it can represent full.
- rx_en deasserts the same cycle full asserts. A word the receiver is already shifting still completes; if the FIFO is still full at capture, it is dropped and flagged.
- Latency: a word captured in cycle N is on rd_data with empty=0 in cycle N+1.

Test Plan:
- Reset then single word: rst low 2 cycles, en=1; rx_busy high 8 cycles then low with rx_data=0xA5 -> next cycle empty=0, count=1, rd_data=0xA5; pulse rd_en -> empty=1, rd_data=0x00.
- Fill and wrap: capture 0x01..0x08 -> full=1, count=8, rx_en=0; pop 3; capture 0x09..0x0B -> pop order 0x04..0x0B, with pointers wrapped past index 7.
- Overflow: FIFO full, capture 0xFF without pop -> count stays 8, head still 0x01, overflow=1. ovf_clr alone -> overflow=0. ovf_clr in the same cycle as another drop -> overflow stays 1.
- Simultaneous push/pop: at count=8, capture 0x55 with rd_en=1 -> count=8, overflow=0, 0x55 is last out. At empty, capture 0x33 with rd_en=1 -> count=1, rd_data=0x33.
- Reset mid-word: rx_busy=1, assert rst for 1 cycle, release with rx_busy still 1 for 4 cycles then 0 -> nothing captured, count=0. The next full busy pulse with 0x5A -> count=1, rd_data=0x5A.
- Pop when empty: rd_en held 5 cycles with empty=1 -> pointers and count unchanged, rd_data=0, no underflow wrap.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART receiver: captures each completed word on the falling
// edge of rx_busy into a first-word-fall-through circular buffer with a sticky overflow flag.
module uart_rx_fifo #(
  parameter int unsigned BIT_WIDTH  = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx_busy,
  input  logic [BIT_WIDTH-1:0]  rx_data,
  output logic                  rx_en,
  input  logic                  rd_en,
  output logic [BIT_WIDTH-1:0]  rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CountOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    StWaitIdle = 2'b00,
    StIdle     = 2'b01,
    StBusy     = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic                   push;
  logic                   push_ok;
  logic                   pop_ok;
  logic                   drop;

  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [BIT_WIDTH-1:0]   mem [Depth];

  // Capture FSM: a word is complete when busy falls after having been seen high.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      StWaitIdle: begin
        if (!rx_busy) state_d = StIdle;
      end
      StIdle: begin
        if (rx_busy) state_d = StBusy;
      end
      StBusy: begin
        if (!rx_busy) begin
          state_d = StIdle;
          push    = 1'b1;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = rd_en && !empty;
  assign push_ok = push && (!full || rd_en);
  assign drop    = push && full && !rd_en;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;

    if (push_ok && !pop_ok) begin
      count_d = count_q + CountOne;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CountOne;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWaitIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= rx_data;
  end

  assign rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rx_en    = en && !full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo using a queue-based reference model
// updated on each clock edge and compared on the opposite edge.
module tb_uart_rx_fifo;

  localparam int unsigned BW    = 8;
  localparam int unsigned DL2   = 3;
  localparam int unsigned DEPTH = 2 ** DL2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           rx_busy;
  logic [BW-1:0]  rx_data;
  logic           rx_en;
  logic           rd_en;
  logic [BW-1:0]  rd_data;
  logic           empty;
  logic           full;
  logic [DL2:0]   count;
  logic           overflow;
  logic           ovf_clr;

  uart_rx_fifo #(
    .BIT_WIDTH  (BW),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rx_busy  (rx_busy),
    .rx_data  (rx_data),
    .rx_en    (rx_en),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Driver marks the cycles in which a complete word ends; the model decides what happens.
  logic tb_cap;
  bit   rand_mode;
  int   pop_pct;

  logic [BW-1:0] mq[$];
  logic          movf;
  bit            m_room, m_pop;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      m_room = (mq.size() < DEPTH);
      m_pop  = rd_en && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (tb_cap) begin
        if (m_room || m_pop) mq.push_back(rx_data);
        else movf = 1'b1;
      end else if (ovf_clr) begin
        movf = 1'b0;
      end
      if (tb_cap && !(m_room || m_pop)) movf = 1'b1;
      else if (tb_cap && ovf_clr) movf = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [BW-1:0]  e_rd;
  logic [DL2:0]   e_cnt;
  logic           e_empty, e_full, e_ovf, e_rxen;

  always @(negedge clk) begin
    if (!rst) begin
      e_rd = '0; e_cnt = '0; e_empty = 1'b1; e_full = 1'b0; e_ovf = 1'b0; e_rxen = en;
    end else begin
      e_cnt   = (DL2 + 1)'(mq.size());
      e_empty = (mq.size() == 0);
      e_full  = (mq.size() == DEPTH);
      e_rd    = e_empty ? '0 : mq[0];
      e_ovf   = movf;
      e_rxen  = en && !e_full;
    end
    check("rd_data",  {24'b0, rd_data}, {24'b0, e_rd});
    check("count",    {28'b0, count},   {28'b0, e_cnt});
    check("empty",    {31'b0, empty},   {31'b0, e_empty});
    check("full",     {31'b0, full},    {31'b0, e_full});
    check("overflow", {31'b0, overflow}, {31'b0, e_ovf});
    check("rx_en",    {31'b0, rx_en},   {31'b0, e_rxen});
  end

  task automatic tick();
    if (rand_mode) begin
      rd_en   = ($urandom_range(99) < pop_pct);
      ovf_clr = ($urandom_range(99) < 5);
      en      = ($urandom_range(9) != 0);
    end
    @(posedge clk);
    #1;
    tb_cap = 1'b0;
  endtask

  task automatic send_word(input logic [BW-1:0] d, input int busy_cycles, input bit pop_at_end);
    rx_busy = 1'b1;
    repeat (busy_cycles) begin
      rx_data = BW'($urandom);
      tick();
    end
    rx_busy = 1'b0;
    rx_data = d;
    tb_cap  = 1'b1;
    if (!rand_mode) rd_en = pop_at_end;
    tick();
    if (!rand_mode) rd_en = 1'b0;
    rx_data = BW'($urandom);
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; rx_busy = 1'b0; rx_data = '0;
    rd_en = 1'b0; ovf_clr = 1'b0; tb_cap = 1'b0; rand_mode = 1'b0; pop_pct = 50;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single word then pop back to empty
    send_word(8'hA5, 8, 1'b0);
    tick();
    pop_n(1);
    tick();

    // Fill to depth, then drops with and without a concurrent clear
    for (int i = 1; i <= DEPTH; i++) send_word(BW'(i), 3, 1'b0);
    tick();
    send_word(8'hFF, 2, 1'b0);
    tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    send_word(8'hEE, 2, 1'b0);
    ovf_clr = 1'b1;
    send_word(8'hDD, 2, 1'b0);
    ovf_clr = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Push and pop together while full, then wrap the pointers
    send_word(8'h55, 2, 1'b1);
    tick();
    pop_n(3);
    send_word(8'h09, 2, 1'b0);
    send_word(8'h0A, 2, 1'b0);
    send_word(8'h0B, 2, 1'b0);
    pop_n(DEPTH + 1);

    // Push and pop together while empty
    send_word(8'h33, 3, 1'b1);
    tick();
    pop_n(1);

    // Pop attempts on an empty FIFO
    pop_n(5);
    tick();

    // Reset while a word is in flight
    rx_busy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    rx_busy = 1'b0;
    tick();
    send_word(8'h5A, 5, 1'b0);
    tick();
    pop_n(1);
    en = 1'b0; tick(); en = 1'b1; tick();

    // Random traffic, cycling through fill-heavy and drain-heavy phases
    rand_mode = 1'b1;
    for (int w = 0; w < 400; w++) begin
      case ((w / 50) % 3)
        0: pop_pct = 10;
        1: pop_pct = 50;
        default: pop_pct = 90;
      endcase
      send_word(BW'($urandom), int'($urandom_range(1, 6)), 1'b0);
      if ($urandom_range(3) == 0) tick();
    end
    rand_mode = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0; en = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
